uart_wb_bridge: RTL and testbench

//  Debug/loader bus master: receives framed commands on a UART line and turns them into single
//  32-bit Wishbone read/write cycles. Drives the interconnect's spare master port (m2), upstream of
//  the ROM/RAM/AES/GPIO/UART slaves, so a host can load RAM and poke peripherals with the CPU held.

---
 rtl/uart_wb_bridge.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_uart_wb_bridge.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: host-facing debug master. Decodes framed 8N1 UART commands
// into single-beat 32-bit Wishbone read/write cycles and answers over UART TX.
module uart_wb_bridge #(
    parameter int CLKS_PER_BIT = 434,
    parameter int WB_TIMEOUT   = 255,
    parameter int BYTE_TIMEOUT = 65535
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    input  logic [31:0] wb_data_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        busy_o
);
    localparam int BIT_W = $clog2(CLKS_PER_BIT);
    localparam logic [BIT_W-1:0] BIT_END  = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] HALF_END = BIT_W'(CLKS_PER_BIT / 2 - 1);
    localparam int WBC_W = $clog2(WB_TIMEOUT);
    localparam logic [WBC_W-1:0] WB_END = WBC_W'(WB_TIMEOUT - 1);
    localparam int GAP_W = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_END = GAP_W'(BYTE_TIMEOUT);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h45;
    localparam logic [7:0] RSP_BAD   = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_WB_REQ = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // Multi-byte fields arrive MSB first, so each new byte enters at the bottom.
    function automatic logic [31:0] shift_in(input logic [31:0] acc, input logic [7:0] b);
        return {acc[23:0], b};
    endfunction

    state_t state_r, state_next;

    logic [1:0]       rx_sync_r;
    logic             rx_prev_r, rx_busy_r, rx_valid_r;
    logic [BIT_W-1:0] rx_cnt_r;
    logic [3:0]       rx_bit_r;
    logic [7:0]       rx_shift_r, rx_byte_r;

    logic             tx_line_r, tx_busy_r, tx_start_s, tx_ready_s;
    logic [BIT_W-1:0] tx_cnt_r;
    logic [3:0]       tx_bit_r;
    logic [8:0]       tx_shift_r;

    logic [31:0]      addr_sh_r, data_sh_r, wb_addr_r, wb_data_r, resp_data_r;
    logic [3:0]       wb_sel_r;
    logic             wb_we_r, wb_cyc_r, cmd_we_r, busy_r;
    logic [1:0]       byte_cnt_r;
    logic [2:0]       resp_cnt_r;
    logic [GAP_W-1:0] gap_cnt_r;
    logic [WBC_W-1:0] wb_cnt_r;

    assign uart_tx_o = tx_line_r;
    assign wb_addr_o = wb_addr_r;
    assign wb_data_o = wb_data_r;
    assign wb_sel_o  = wb_sel_r;
    assign wb_we_o   = wb_we_r;
    assign wb_cyc_o  = wb_cyc_r;
    assign wb_stb_o  = wb_cyc_r;
    assign busy_o    = busy_r;

    // TX may take a new byte when idle or in the final cycle of a stop bit (back-to-back).
    assign tx_ready_s = !tx_busy_r || (tx_bit_r == 4'd9 && tx_cnt_r == BIT_END);

    // RX: synchronise the line, qualify the start bit at mid-bit, sample data at bit centres.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_sync_r  <= 2'b11;
            rx_prev_r  <= 1'b1;
            rx_busy_r  <= 1'b0;
            rx_cnt_r   <= '0;
            rx_bit_r   <= 4'd0;
            rx_shift_r <= 8'h00;
            rx_valid_r <= 1'b0;
            rx_byte_r  <= 8'h00;
        end else begin
            rx_sync_r  <= {rx_sync_r[0], uart_rx_i};
            rx_prev_r  <= rx_sync_r[1];
            rx_valid_r <= 1'b0;
            if (!rx_busy_r) begin
                if (rx_prev_r && !rx_sync_r[1]) begin
                    rx_busy_r <= 1'b1;
                    rx_cnt_r  <= '0;
                    rx_bit_r  <= 4'd0;
                end
            end else if (rx_bit_r == 4'd0) begin
                if (rx_cnt_r == HALF_END) begin
                    if (rx_sync_r[1]) begin
                        rx_busy_r <= 1'b0;          // glitch, not a real start bit
                    end else begin
                        rx_bit_r <= 4'd1;
                        rx_cnt_r <= '0;
                    end
                end else begin
                    rx_cnt_r <= rx_cnt_r + BIT_W'(1);
                end
            end else if (rx_cnt_r == BIT_END) begin
                rx_cnt_r <= '0;
                if (rx_bit_r == 4'd9) begin
                    rx_busy_r <= 1'b0;
                    if (rx_sync_r[1]) begin         // low stop bit: framing error, byte dropped
                        rx_valid_r <= 1'b1;
                        rx_byte_r  <= rx_shift_r;
                    end
                end else begin
                    rx_shift_r <= {rx_sync_r[1], rx_shift_r[7:1]};
                    rx_bit_r   <= rx_bit_r + 4'd1;
                end
            end else begin
                rx_cnt_r <= rx_cnt_r + BIT_W'(1);
            end
        end
    end

    // TX: shift out start, 8 data bits LSB first, stop; reset forces the line high at once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_line_r  <= 1'b1;
            tx_busy_r  <= 1'b0;
            tx_cnt_r   <= '0;
            tx_bit_r   <= 4'd0;
            tx_shift_r <= 9'h1FF;
        end else if (tx_start_s) begin
            tx_line_r  <= 1'b0;
            tx_shift_r <= {1'b1, resp_data_r[31:24]};
            tx_busy_r  <= 1'b1;
            tx_cnt_r   <= '0;
            tx_bit_r   <= 4'd0;
        end else if (tx_busy_r) begin
            if (tx_cnt_r == BIT_END) begin
                tx_cnt_r <= '0;
                if (tx_bit_r == 4'd9) begin
                    tx_busy_r <= 1'b0;
                    tx_line_r <= 1'b1;
                end else begin
                    tx_line_r  <= tx_shift_r[0];
                    tx_shift_r <= {1'b1, tx_shift_r[8:1]};
                    tx_bit_r   <= tx_bit_r + 4'd1;
                end
            end else begin
                tx_cnt_r <= tx_cnt_r + BIT_W'(1);
            end
        end
    end

    // Parser FSM next-state and TX launch decode.
    always_comb begin
        state_next = state_r;
        tx_start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_valid_r) begin
                    if (rx_byte_r == CMD_WRITE || rx_byte_r == CMD_READ) state_next = ST_ADDR;
                    else state_next = ST_RESP;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (rx_valid_r) begin
                    if (byte_cnt_r == 2'd3) state_next = cmd_we_r ? ST_DATA : ST_WB_REQ;
                    else state_next = ST_ADDR;
                end else if (gap_cnt_r == GAP_END) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (rx_valid_r) begin
                    if (byte_cnt_r == 2'd3) state_next = ST_WB_REQ;
                    else state_next = ST_DATA;
                end else if (gap_cnt_r == GAP_END) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_DATA;
                end
            end
            ST_WB_REQ: begin
                if (wb_ack_i || wb_cnt_r == WB_END) state_next = ST_RESP;
                else state_next = ST_WB_REQ;
            end
            ST_RESP: begin
                if (tx_ready_s) begin
                    if (resp_cnt_r != 3'd0) tx_start_s = 1'b1;
                    else state_next = ST_IDLE;
                end else begin
                    state_next = ST_RESP;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Parser datapath: collect fields, run the bus cycle, queue reply bytes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            wb_cyc_r    <= 1'b0;
            wb_we_r     <= 1'b0;
            wb_sel_r    <= 4'h0;
            wb_addr_r   <= 32'h0;
            wb_data_r   <= 32'h0;
            addr_sh_r   <= 32'h0;
            data_sh_r   <= 32'h0;
            cmd_we_r    <= 1'b0;
            byte_cnt_r  <= 2'd0;
            gap_cnt_r   <= '0;
            wb_cnt_r    <= '0;
            resp_data_r <= 32'h0;
            resp_cnt_r  <= 3'd0;
        end else begin
            state_r <= state_next;
            busy_r  <= (state_next != ST_IDLE);
            if ((state_r == ST_ADDR || state_r == ST_DATA) && !rx_valid_r) gap_cnt_r <= gap_cnt_r + GAP_W'(1);
            else gap_cnt_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (rx_valid_r) begin
                        byte_cnt_r <= 2'd0;
                        cmd_we_r   <= (rx_byte_r == CMD_WRITE);
                        if (rx_byte_r != CMD_WRITE && rx_byte_r != CMD_READ) begin
                            resp_data_r <= {RSP_BAD, 24'h0};
                            resp_cnt_r  <= 3'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_valid_r) begin
                        addr_sh_r  <= shift_in(addr_sh_r, rx_byte_r);
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3 && !cmd_we_r) begin
                            wb_addr_r <= shift_in(addr_sh_r, rx_byte_r);
                            wb_cyc_r  <= 1'b1;
                            wb_sel_r  <= 4'hF;
                            wb_we_r   <= 1'b0;
                            wb_cnt_r  <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_valid_r) begin
                        data_sh_r  <= shift_in(data_sh_r, rx_byte_r);
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            wb_addr_r <= addr_sh_r;
                            wb_data_r <= shift_in(data_sh_r, rx_byte_r);
                            wb_cyc_r  <= 1'b1;
                            wb_sel_r  <= 4'hF;
                            wb_we_r   <= 1'b1;
                            wb_cnt_r  <= '0;
                        end
                    end
                end
                ST_WB_REQ: begin
                    wb_cnt_r <= wb_cnt_r + WBC_W'(1);
                    if (wb_ack_i) begin
                        wb_cyc_r <= 1'b0;
                        wb_sel_r <= 4'h0;
                        wb_we_r  <= 1'b0;
                        if (wb_we_r) begin
                            resp_data_r <= {RSP_OK, 24'h0};
                            resp_cnt_r  <= 3'd1;
                        end else begin
                            resp_data_r <= wb_data_i;
                            resp_cnt_r  <= 3'd4;
                        end
                    end else if (wb_cnt_r == WB_END) begin
                        wb_cyc_r    <= 1'b0;
                        wb_sel_r    <= 4'h0;
                        wb_we_r     <= 1'b0;
                        resp_data_r <= {RSP_ERR, 24'h0};
                        resp_cnt_r  <= 3'd1;
                    end
                end
                ST_RESP: begin
                    if (tx_start_s) begin
                        resp_data_r <= {resp_data_r[23:0], 8'h00};
                        resp_cnt_r  <= resp_cnt_r - 3'd1;
                    end
                end
                default: begin
                    wb_cyc_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_wb_bridge.sv
// Testbench for uart_wb_bridge: UART host driver, Wishbone slave model and
// scoreboard queues for expected bus cycles and reply bytes.
module tb_uart_wb_bridge;
    localparam int CPB = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic [3:0]  sel;
    } wb_rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        uart_tx_o, wb_we_o, wb_cyc_o, wb_stb_o, busy_o;
    logic [31:0] wb_addr_o, wb_data_o;
    logic [31:0] wb_data_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_tx_q[$];
    logic [7:0] obs_tx_q[$];
    wb_rec_t    exp_wb_q[$];
    wb_rec_t    obs_wb_q[$];
    bit          ack_en = 1'b1;
    int          ack_delay = 3;
    logic [31:0] rd_data = 32'h0;
    bit          stray_ack = 1'b0;
    int          stb_cnt = 0;
    int          last_len = 0;
    int          cyc_count = 0;
    int          viol = 0;
    logic [31:0] last_wdata = 32'h0;

    always #5 clk = ~clk;

    uart_wb_bridge #(.CLKS_PER_BIT(CPB), .WB_TIMEOUT(16), .BYTE_TIMEOUT(200)) dut (
        .clk_i(clk), .rst_i(rst), .uart_rx_i(rx), .uart_tx_o(uart_tx_o),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .busy_o(busy_o)
    );

    // Wishbone slave model: records each cycle, acks after ack_delay, checks idle bus levels.
    initial begin
        wb_ack_i = 1'b0;
        wb_data_i = 32'h0;
        forever begin
            @(negedge clk);
            if (wb_cyc_o === 1'b1) begin
                if (stb_cnt == 0) obs_wb_q.push_back({wb_addr_o, wb_data_o, wb_we_o, wb_sel_o});
                if (wb_stb_o !== 1'b1 || wb_sel_o !== 4'hF) viol++;
                stb_cnt++;
                if (ack_en && stb_cnt == ack_delay + 1) begin
                    wb_ack_i = 1'b1;
                    wb_data_i = rd_data;
                end else begin
                    wb_ack_i = 1'b0;
                    wb_data_i = 32'h0;
                end
            end else begin
                if (stb_cnt != 0) begin
                    last_len = stb_cnt;
                    cyc_count++;
                end
                stb_cnt = 0;
                if (wb_stb_o !== 1'b0 || wb_sel_o !== 4'h0 || wb_we_o !== 1'b0) viol++;
                wb_ack_i = stray_ack;
                wb_data_i = 32'h0;
            end
        end
    end

    // UART receive monitor: decodes reply bytes from uart_tx_o into obs_tx_q.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (uart_tx_o === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                if (uart_tx_o === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        b[i] = uart_tx_o;
                    end
                    repeat (CPB) @(negedge clk);
                    if (uart_tx_o !== 1'b1) viol++;
                    obs_tx_q.push_back(b);
                end
            end
        end
    end

    task automatic uart_send(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_bytes(input logic [71:0] v, input int n);
        for (int i = 0; i < n; i++) uart_send(v[8*(n-1-i) +: 8], 1'b0);
    endtask

    task automatic wait_tx(input int n, output bit ok);
        int t = 0;
        while (obs_tx_q.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        ok = (obs_tx_q.size() >= n);
    endtask

    task automatic wait_idle(output bit ok);
        int t = 0;
        while (busy_o !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        ok = (busy_o === 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({uart_tx_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, busy_o} !== 9'h100) begin
            errors++;
            $display("FAIL reset_ctrl got %b want %b", {uart_tx_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, busy_o}, 9'h100);
        end
        checks++;
        if (wb_addr_o !== 32'h0 || wb_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr_data got %h/%h want 0/0", wb_addr_o, wb_data_o);
        end
        rst = 1'b0;
        stray_ack = 1'b1;
        repeat (5) @(negedge clk);
        stray_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cyc_count !== 0 || busy_o !== 1'b0 || obs_wb_q.size() != 0) begin
            errors++;
            $display("FAIL stray_ack got cycles %0d busy %b want 0 0", cyc_count, busy_o);
        end
    endtask

    task automatic test_write();
        logic [7:0] e8, o8;
        wb_rec_t ew, ow;
        bit ok;
        int n0 = cyc_count;
        ack_en = 1'b1;
        ack_delay = 3;
        exp_wb_q.push_back({32'h00001000, 32'hDEADBEEF, 1'b1, 4'hF});
        exp_tx_q.push_back(8'h4B);
        last_wdata = 32'hDEADBEEF;
        send_bytes(72'h57_00001000_DEADBEEF, 9);
        wait_tx(1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL write_tx_timeout got %0d bytes want 1", obs_tx_q.size()); end
        while (exp_tx_q.size() != 0 && obs_tx_q.size() != 0) begin
            e8 = exp_tx_q.pop_front();
            o8 = obs_tx_q.pop_front();
            checks++;
            if (o8 !== e8) begin errors++; $display("FAIL write_tx got %h want %h", o8, e8); end
        end
        while (exp_wb_q.size() != 0) begin
            ew = exp_wb_q.pop_front();
            checks++;
            if (obs_wb_q.size() == 0) begin errors++; $display("FAIL write_wb got none want %h", ew); end
            else begin
                ow = obs_wb_q.pop_front();
                if (ow !== ew) begin errors++; $display("FAIL write_wb got %h want %h", ow, ew); end
            end
        end
        wait_idle(ok);
        checks++;
        if (!ok || cyc_count - n0 != 1 || last_len != ack_delay + 1) begin
            errors++;
            $display("FAIL write_cycle got idle %b cycles %0d len %0d want 1 1 %0d", ok, cyc_count - n0, last_len, ack_delay + 1);
        end
        checks++;
        if (wb_addr_o !== 32'h00001000 || wb_data_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_hold got %h/%h want 00001000/deadbeef", wb_addr_o, wb_data_o);
        end
    endtask

    task automatic test_read(input logic [31:0] addr, input logic [31:0] data, input string nm);
        logic [7:0] e8, o8;
        wb_rec_t ew, ow;
        bit ok;
        ack_en = 1'b1;
        ack_delay = 1;
        rd_data = data;
        exp_wb_q.push_back({addr, last_wdata, 1'b0, 4'hF});
        for (int i = 3; i >= 0; i--) exp_tx_q.push_back(data[8*i +: 8]);
        send_bytes({32'h0, 8'h52, addr}, 5);
        wait_tx(4, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_tx_timeout got %0d bytes want 4", nm, obs_tx_q.size()); end
        while (exp_tx_q.size() != 0 && obs_tx_q.size() != 0) begin
            e8 = exp_tx_q.pop_front();
            o8 = obs_tx_q.pop_front();
            checks++;
            if (o8 !== e8) begin errors++; $display("FAIL %s_tx got %h want %h", nm, o8, e8); end
        end
        exp_tx_q.delete();
        while (exp_wb_q.size() != 0) begin
            ew = exp_wb_q.pop_front();
            checks++;
            if (obs_wb_q.size() == 0) begin errors++; $display("FAIL %s_wb got none want %h", nm, ew); end
            else begin
                ow = obs_wb_q.pop_front();
                if (ow !== ew) begin errors++; $display("FAIL %s_wb got %h want %h", nm, ow, ew); end
            end
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_idle got busy %b want 0", nm, busy_o); end
    endtask

    task automatic test_bad_cmd();
        logic [7:0] o8;
        bit ok;
        int n0 = cyc_count;
        exp_tx_q.push_back(8'h3F);
        uart_send(8'h41, 1'b0);
        wait_tx(1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bad_tx_timeout got %0d bytes want 1", obs_tx_q.size()); end
        else begin
            o8 = obs_tx_q.pop_front();
            checks++;
            if (o8 !== exp_tx_q[0]) begin errors++; $display("FAIL bad_tx got %h want %h", o8, exp_tx_q[0]); end
        end
        exp_tx_q.delete();
        wait_idle(ok);
        checks++;
        if (!ok || cyc_count != n0 || obs_wb_q.size() != 0) begin
            errors++;
            $display("FAIL bad_no_cycle got idle %b cycles %0d want 1 0", ok, cyc_count - n0);
        end
        test_read(32'h0000000C, 32'hCAFEF00D, "after_bad");
    endtask

    task automatic test_timeout();
        logic [7:0] o8;
        bit ok;
        ack_en = 1'b0;
        exp_wb_q.push_back({32'h0, last_wdata, 1'b0, 4'hF});
        exp_tx_q.push_back(8'h45);
        send_bytes(72'h52_00000000, 5);
        wait_tx(1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL to_tx_timeout got %0d bytes want 1", obs_tx_q.size()); end
        else begin
            o8 = obs_tx_q.pop_front();
            checks++;
            if (o8 !== exp_tx_q[0]) begin errors++; $display("FAIL to_tx got %h want %h", o8, exp_tx_q[0]); end
        end
        exp_tx_q.delete();
        checks++;
        if (obs_wb_q.size() == 0 || obs_wb_q[0] !== exp_wb_q[0]) begin
            errors++;
            $display("FAIL to_wb got %0d cycles want %h", obs_wb_q.size(), exp_wb_q[0]);
        end
        obs_wb_q.delete();
        exp_wb_q.delete();
        wait_idle(ok);
        checks++;
        if (!ok || last_len != 16) begin
            errors++;
            $display("FAIL to_len got idle %b len %0d want 1 16", ok, last_len);
        end
        ack_en = 1'b1;
    endtask

    task automatic test_byte_timeout();
        int n0 = cyc_count;
        send_bytes(72'h57_0000, 3);
        repeat (300) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || obs_tx_q.size() != 0 || cyc_count != n0) begin
            errors++;
            $display("FAIL gap_abort got busy %b bytes %0d cycles %0d want 0 0 0", busy_o, obs_tx_q.size(), cyc_count - n0);
        end
        test_read(32'h00000008, 32'h0BADCAFE, "after_gap");
    endtask

    task automatic test_frame_err_reset();
        wb_rec_t ow, ew;
        int t = 0;
        int highs_bad = 0;
        ack_en = 1'b0;
        ew = {32'h00002000, 32'h11223344, 1'b1, 4'hF};
        send_bytes(72'h57_0000, 3);
        uart_send(8'h55, 1'b1);
        send_bytes(72'h2000_11223344, 6);
        while (wb_cyc_o !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL ferr_cyc got %b want 1", wb_cyc_o); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({wb_cyc_o, wb_stb_o, busy_o, uart_tx_o} !== 4'b0001) begin
            errors++;
            $display("FAIL rst_abort got %b want 0001", {wb_cyc_o, wb_stb_o, busy_o, uart_tx_o});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (uart_tx_o !== 1'b1 || busy_o !== 1'b0) highs_bad++;
        end
        checks++;
        if (highs_bad != 0 || obs_tx_q.size() != 0) begin
            errors++;
            $display("FAIL rst_quiet got %0d bad cycles %0d bytes want 0 0", highs_bad, obs_tx_q.size());
        end
        checks++;
        if (obs_wb_q.size() == 0) begin errors++; $display("FAIL ferr_wb got none want %h", ew); end
        else begin
            ow = obs_wb_q.pop_front();
            if (ow !== ew) begin errors++; $display("FAIL ferr_wb got %h want %h", ow, ew); end
        end
        checks++;
        if (wb_addr_o !== 32'h0 || wb_data_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_addr got %h/%h want 0/0", wb_addr_o, wb_data_o);
        end
        ack_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read(32'h30000004, 32'h12345678, "read");
        test_bad_cmd();
        test_timeout();
        test_byte_timeout();
        test_frame_err_reset();
        checks++;
        if (viol != 0 || obs_wb_q.size() != 0 || obs_tx_q.size() != 0) begin
            errors++;
            $display("FAIL bus_rules got viol %0d extra cycles %0d extra bytes %0d want 0 0 0", viol, obs_wb_q.size(), obs_tx_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
